apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter: DATA_W, 5, width of pwdata/prdata/request/response data.
REQ-002 SHALL have parameter: ADDR_W, 3, width of paddr/req_addr.
REQ-003 SHALL have parameter: TIMEOUT, 15, max ACCESS cycles with pready low before abort (range 1..255).
REQ-004 SHALL have one clock and asynchronous active-low reset: pclk  in  1  rising-edge clock for all state.
REQ-005 preset  in  1  asynchronous, active-low reset (0 = reset).
REQ-006 req_valid  in  1  command request valid.
REQ-007 req_ready  out  1  master can accept a command.
REQ-008 req_write  in  1  1 = write, 0 = read.
REQ-009 req_addr  in  ADDR_W  target address.
REQ-010 req_wdata  in  DATA_W  write data.
REQ-011 rsp_valid  out  1  one-cycle completion pulse.
REQ-012 rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts.
REQ-013 rsp_err  out  1  transfer aborted by timeout; valid with rsp_valid.
REQ-014 psel, penable, pwrite  out  1 each  APB control to slave.
REQ-015 paddr  out  ADDR_W; pwdata  out  DATA_W  APB address/write data.
REQ-016 prdata  in  DATA_W; pready  in  1  APB slave response.

Function
REQ-017 SHALL implement FSM IDLE, SETUP, ACCESS; all outputs registered.
REQ-018 req_ready SHALL be 1 only in IDLE; command accepted at a rising edge with req_valid&req_ready, captured into pwrite/paddr/pwdata, next state SETUP.
REQ-019 SETUP: psel=1, penable=0, exactly one cycle, then ACCESS.
REQ-020 ACCESS: psel=1, penable=1; stays while pready=0 and wait count < TIMEOUT.
REQ-021 ACCESS with pready=1 at an edge SHALL go to IDLE, psel=penable=0, rsp_valid=1 for next cycle, rsp_err=0, rsp_rdata=prdata sampled at that edge if read, else 0.
REQ-022 Wait counter SHALL clear on entering ACCESS and increment each ACCESS edge with pready=0; at the edge where count reaches TIMEOUT with pready=0, SHALL go to IDLE with rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-023 pready=1 on the timeout edge SHALL take priority: normal completion, rsp_err=0.
REQ-024 pready and prdata SHALL be ignored in IDLE and SETUP.
REQ-025 pwrite/paddr/pwdata SHALL stay stable from SETUP through end of ACCESS and hold last values in IDLE.
REQ-026 rsp_valid SHALL be high exactly one cycle per transfer; rsp_rdata/rsp_err hold until next completion.
REQ-027 Latency: zero-wait transfer accepted at edge E0 SHALL show rsp_valid in cycle after E2; with continuous req_valid, one transfer per 3 cycles (+ wait states).
REQ-028 A new command MAY be accepted in the same cycle rsp_valid is high.

Reset
REQ-029 preset=0 SHALL immediately force IDLE, counter=0, and psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err to 0; req_ready=1 after deassertion.
REQ-030 Reset mid-transfer SHALL drop the transfer with no rsp_valid; first command accepted on first edge after release.

Structure
REQ-031 Shared package apb_pkg SHALL hold the FSM state type (IDLE/SETUP/ACCESS) and default DATA_W=5, ADDR_W=3, TIMEOUT=15 constants.
REQ-032 Wait counter SHALL be a sub-module apb_timeout_counter (clear, enable, limit, expired output); FSM stays in apb_master.

Verification
REQ-033 Write addr 3, data 0x15, pready=1 in ACCESS -> psel 1 cycle after accept, penable next, rsp_valid=1, rsp_err=0, rsp_rdata=0, pwdata=0x15, paddr=3 throughout.
REQ-034 Read addr 3, pready low 2 ACCESS cycles then high with prdata=0x15 -> ACCESS lasts 3 cycles, rsp_rdata=0x15, rsp_err=0.
REQ-035 TIMEOUT=15, pready held 0 -> ACCESS exits after 15 waiting edges, rsp_valid=1, rsp_err=1, rsp_rdata=0; pready=1 on 15th edge instead -> rsp_err=0.
REQ-036 preset low during ACCESS -> psel/penable/rsp_valid 0 without waiting for clock edge, no response after release, next command normal.
REQ-037 req_valid held high for write then read -> req_ready low during SETUP/ACCESS, second SETUP 1 cycle after first rsp_valid, 3-cycle spacing.
REQ-038 pready=1 and prdata=0x1F during IDLE/SETUP -> no early completion, ACCESS still entered.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and default sizing for the APB master and its wait counter.
package apb_pkg;
  localparam int DEF_DATA_W  = 5;
  localparam int DEF_ADDR_W  = 3;
  localparam int DEF_TIMEOUT = 15;
  // Wide enough for the largest supported TIMEOUT of 255.
  localparam int CNT_W       = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;
endpackage

// File: rtl/apb_timeout_counter.sv
// ACCESS wait-state counter; expired flags the enabled edge at which the count reaches limit.
module apb_timeout_counter
  import apb_pkg::*;
(
  input  logic             pclk,
  input  logic             preset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);
  logic [CNT_W-1:0] count;

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  // Combinational look-ahead so the FSM can abort on the very edge the limit is hit.
  assign expired = enable && (count == limit - CNT_W'(1));
endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master: command -> SETUP -> ACCESS -> one-cycle response pulse.
// All outputs are registered; ACCESS is aborted with rsp_err after TIMEOUT wait states.
module apb_master
  import apb_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  apb_state_t        state, state_nxt;
  logic              req_ready_nxt, rsp_valid_nxt, rsp_err_nxt;
  logic              psel_nxt, penable_nxt, pwrite_nxt;
  logic [ADDR_W-1:0] paddr_nxt;
  logic [DATA_W-1:0] pwdata_nxt, rsp_rdata_nxt;
  logic              cnt_clear, cnt_en, cnt_expired;

  apb_timeout_counter u_wait_cnt (
    .pclk    (pclk),
    .preset  (preset),
    .clear   (cnt_clear),
    .enable  (cnt_en),
    .limit   (LIMIT),
    .expired (cnt_expired)
  );

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      req_ready <= req_ready_nxt;
      psel      <= psel_nxt;
      penable   <= penable_nxt;
      pwrite    <= pwrite_nxt;
      paddr     <= paddr_nxt;
      pwdata    <= pwdata_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      rsp_err   <= rsp_err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    req_ready_nxt = req_ready;
    psel_nxt      = psel;
    penable_nxt   = penable;
    pwrite_nxt    = pwrite;
    paddr_nxt     = paddr;
    pwdata_nxt    = pwdata;
    rsp_valid_nxt = 1'b0;
    rsp_rdata_nxt = rsp_rdata;
    rsp_err_nxt   = rsp_err;
    cnt_clear     = 1'b0;
    cnt_en        = 1'b0;

    unique case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          state_nxt     = SETUP;
          req_ready_nxt = 1'b0;
          psel_nxt      = 1'b1;
          penable_nxt   = 1'b0;
          pwrite_nxt    = req_write;
          paddr_nxt     = req_addr;
          pwdata_nxt    = req_wdata;
        end
      end
      SETUP: begin
        state_nxt   = ACCESS;
        penable_nxt = 1'b1;
        cnt_clear   = 1'b1;
      end
      ACCESS: begin
        // pready wins over an expiring counter on the same edge.
        if (pready) begin
          state_nxt     = IDLE;
          req_ready_nxt = 1'b1;
          psel_nxt      = 1'b0;
          penable_nxt   = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = 1'b0;
          rsp_rdata_nxt = pwrite ? '0 : prdata;
        end else begin
          cnt_en = 1'b1;
          if (cnt_expired) begin
            state_nxt     = IDLE;
            req_ready_nxt = 1'b1;
            psel_nxt      = 1'b0;
            penable_nxt   = 1'b0;
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = 1'b1;
            rsp_rdata_nxt = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_apb_master.sv
// Randomized bench for apb_master: driver + reactive slave feed a scoreboard checked by a monitor.
module tb_apb_master;
  localparam int DW = 5;
  localparam int AW = 3;
  localparam int TO = 15;
  localparam int PER = 10;

  logic          pclk, preset;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr, paddr;
  logic [DW-1:0] req_wdata, pwdata, rsp_rdata, prdata;
  logic          rsp_valid, rsp_err, psel, penable, pwrite, pready;

  apb_master #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready)
  );

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          err;
    int            len;
    longint        t_acc;
  } exp_t;

  typedef struct {
    int            w;
    logic [DW-1:0] rd;
  } slv_t;

  exp_t exp_q[$];
  slv_t slv_q[$];
  int   tests = 0;
  int   fails = 0;

  initial pclk = 1'b0;
  always #(PER/2) pclk = ~pclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, expv, $time);
    end
  endtask

  // Reference: w = number of ACCESS cycles the slave holds pready low before answering.
  function automatic exp_t model(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                 input int w, input logic [DW-1:0] rd);
    exp_t e;
    e.wr    = wr;
    e.addr  = a;
    e.wdata = d;
    e.err   = (w >= TO);
    e.len   = e.err ? TO : w + 1;
    e.rdata = (wr || e.err) ? '0 : rd;
    e.t_acc = 0;
    return e;
  endfunction

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int w, input logic [DW-1:0] rd);
    int   guard = 0;
    bit   hs;
    exp_t e;
    slv_t s;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    forever begin
      hs = req_ready;
      @(posedge pclk);
      if (hs) break;
      @(negedge pclk);
      guard++;
      if (guard > 100) break;
    end
    if (!hs) begin
      chk("accept_timeout", 0, 1);
    end else begin
      e = model(wr, a, d, w, rd);
      e.t_acc = longint'($time);
      s.w  = w;
      s.rd = rd;
      exp_q.push_back(e);
      slv_q.push_back(s);
    end
    @(negedge pclk);
  endtask

  // Reactive slave: garbage outside ACCESS, pready after the planned number of waits.
  int            s_acnt = 0;
  int            s_w = 0;
  logic [DW-1:0] s_rd = '0;
  always @(negedge pclk) begin
    if (!preset) begin
      s_acnt = 0;
      pready = 1'b0;
      prdata = '0;
    end else if (psel && !penable) begin
      if (slv_q.size() > 0) begin
        s_w  = slv_q[0].w;
        s_rd = slv_q[0].rd;
        void'(slv_q.pop_front());
      end
      s_acnt = 0;
      pready = 1'($urandom_range(0, 1));
      prdata = pready ? 5'h1F : DW'($urandom);
    end else if (psel && penable) begin
      if (s_acnt == s_w) begin
        pready = 1'b1;
        prdata = s_rd;
      end else begin
        pready = 1'b0;
        prdata = DW'($urandom);
      end
      s_acnt++;
    end else begin
      pready = 1'($urandom_range(0, 1));
      prdata = pready ? 5'h1F : DW'($urandom);
    end
  end

  // Monitor / scoreboard.
  bit            m_in = 0;
  int            m_acc = 0;
  longint        m_tsetup = 0;
  logic [DW-1:0] m_last_rdata = '0;
  logic          m_last_err = 1'b0;
  always @(negedge pclk) begin
    if (!preset) begin
      m_in = 0;
      m_acc = 0;
      m_last_rdata = '0;
      m_last_err = 1'b0;
    end else begin
      chk("req_ready_vs_idle", req_ready, !psel);
      if (psel && !penable) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_setup", 1, 0);
        end else begin
          chk("setup_delay", longint'($time) - exp_q[0].t_acc, PER/2);
          chk("setup_paddr", paddr, exp_q[0].addr);
          chk("setup_pwrite", pwrite, exp_q[0].wr);
          chk("setup_pwdata", pwdata, exp_q[0].wdata);
          m_tsetup = longint'($time);
          m_acc = 0;
          m_in = 1;
        end
      end else if (psel && penable) begin
        m_acc++;
        if (m_in && exp_q.size() > 0) begin
          chk("access_paddr", paddr, exp_q[0].addr);
          chk("access_pwrite", pwrite, exp_q[0].wr);
          chk("access_pwdata", pwdata, exp_q[0].wdata);
        end
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0 || !m_in) begin
          chk("unexpected_rsp_valid", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", rsp_err, e.err);
          chk("access_cycles", m_acc, e.len);
          chk("setup_to_rsp", longint'($time) - m_tsetup, (e.len + 1) * PER);
          chk("rsp_psel_low", psel, 0);
        end
        m_last_rdata = rsp_rdata;
        m_last_err   = rsp_err;
        m_in = 0;
      end else if (!psel) begin
        chk("rsp_rdata_hold", rsp_rdata, m_last_rdata);
        chk("rsp_err_hold", rsp_err, m_last_err);
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_psel"}, psel, 0);
    chk({tag, "_penable"}, penable, 0);
    chk({tag, "_pwrite"}, pwrite, 0);
    chk({tag, "_paddr"}, paddr, 0);
    chk({tag, "_pwdata"}, pwdata, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
  endtask

  initial begin
    int guard;
    preset    = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (2) @(negedge pclk);
    chk_reset_outputs("reset");
    preset = 1'b1;
    @(negedge pclk);
    chk("ready_after_reset", req_ready, 1);

    // Directed: zero-wait write, read with 2 waits, timeout boundaries.
    issue(1'b1, 3'd3, 5'h15, 0, 5'h00);
    issue(1'b0, 3'd3, 5'h00, 2, 5'h15);
    issue(1'b0, 3'd1, 5'h00, TO, 5'h0A);
    issue(1'b0, 3'd2, 5'h00, TO - 1, 5'h0B);
    issue(1'b1, 3'd7, 5'h1E, TO + 3, 5'h00);
    // Back-to-back write then read with req_valid held high.
    issue(1'b1, 3'd4, 5'h0C, 0, 5'h00);
    issue(1'b0, 3'd5, 5'h00, 0, 5'h13);
    req_valid = 1'b0;
    repeat (3) @(negedge pclk);

    // Reset during ACCESS: drop the transfer, then the next command proceeds normally.
    issue(1'b0, 3'd6, 5'h00, 10, 5'h07);
    req_valid = 1'b0;
    guard = 0;
    while (!(psel && penable) && guard < 20) begin
      @(negedge pclk);
      guard++;
    end
    chk("reached_access", psel && penable, 1);
    repeat (2) @(negedge pclk);
    #2;
    preset = 1'b0;
    exp_q.delete();
    slv_q.delete();
    #1;
    chk_reset_outputs("async_reset");
    repeat (2) @(negedge pclk);
    preset = 1'b1;
    issue(1'b1, 3'd6, 5'h09, 1, 5'h00);

    // Randomized traffic with and without idle gaps.
    for (int i = 0; i < 150; i++) begin
      logic          wr;
      logic [AW-1:0] a;
      logic [DW-1:0] d, rd;
      int            w;
      wr = 1'($urandom_range(0, 1));
      a  = AW'($urandom);
      d  = DW'($urandom);
      rd = DW'($urandom);
      w  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO - 2, TO + 2))
                                       : int'($urandom_range(0, 3));
      issue(wr, a, d, w, rd);
      if ($urandom_range(0, 1) == 1) begin
        req_valid = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge pclk);
      end
    end

    req_valid = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge pclk);
      guard++;
    end
    chk("drain_empty", exp_q.size(), 0);
    repeat (3) @(negedge pclk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
